// File: rtl/game_pkg.sv
// game_pkg: screen geometry, gun/bullet alignment constants, colours and the bullet FSM encoding.
package game_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SPAWN_Y = 427;
  localparam int BARREL_OFS = 3;
  localparam logic [5:0] COL_BLACK = 6'b000000;
  localparam logic [5:0] COL_BULLET = 6'b111100;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FLYING = 2'd1, ST_COOLDOWN = 2'd2} state_t;
endpackage

// File: rtl/rect_hit.sv
// rect_hit: combinational overlap test of rectangle a against rectangle b (half-open extents).
module rect_hit (
  input  logic [10:0] ax,
  input  logic [10:0] ay,
  input  logic [10:0] aw,
  input  logic [10:0] ah,
  input  logic [10:0] bx,
  input  logic [10:0] by,
  input  logic [10:0] bw,
  input  logic [10:0] bh,
  output logic        match
);
  assign match = (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);
endmodule

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: launches one upward bullet from the gun barrel, tests it against the duck,
// draws it into the pixel mux and keeps the per-round ammo count.
module bullet_ctrl #(
  parameter int TICK_DIV = 25000,
  parameter int BULLET_W = 4,
  parameter int BULLET_H = 8,
  parameter int SPAWN_Y = game_pkg::SPAWN_Y,
  parameter int BARREL_OFS = game_pkg::BARREL_OFS,
  parameter int DUCK_W = 32,
  parameter int DUCK_H = 32,
  parameter int AMMO_MAX = 3,
  parameter int COOLDOWN = 8,
  parameter logic [5:0] COLOR = game_pkg::COL_BULLET
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic [9:0] pos_x,
  input  logic       fire,
  input  logic       reload,
  input  logic [9:0] duck_x,
  input  logic [9:0] duck_y,
  input  logic       duck_alive,
  output logic [5:0] data,
  output logic       draw,
  output logic       hit,
  output logic       miss,
  output logic [1:0] ammo,
  output logic       busy
);
  import game_pkg::*;
  localparam int CW = $clog2(COOLDOWN + 1);
  state_t state, state_n;
  logic [15:0] cnt;
  logic tick, fire_q, fire_rise, duck_ov, pix_ov, hit_n, miss_n;
  logic [10:0] bul_x, bul_x_n;
  logic [9:0] bul_y, bul_y_n;
  logic [CW-1:0] cd, cd_n;
  logic [1:0] ammo_n;
  assign tick = cnt == 16'(TICK_DIV - 1);
  assign fire_rise = fire & ~fire_q;
  assign busy = state != ST_IDLE;
  rect_hit u_duck (
    .ax(bul_x), .ay({1'b0, bul_y}), .aw(11'(BULLET_W)), .ah(11'(BULLET_H)),
    .bx({1'b0, duck_x}), .by({1'b0, duck_y}), .bw(11'(DUCK_W)), .bh(11'(DUCK_H)),
    .match(duck_ov)
  );
  // The current pixel is a 1x1 rectangle tested against the bullet box.
  rect_hit u_pix (
    .ax({1'b0, hcount}), .ay({1'b0, vcount}), .aw(11'd1), .ah(11'd1),
    .bx(bul_x), .by({1'b0, bul_y}), .bw(11'(BULLET_W)), .bh(11'(BULLET_H)),
    .match(pix_ov)
  );
  always_comb begin
    state_n = state;
    bul_x_n = bul_x;
    bul_y_n = bul_y;
    cd_n = cd;
    ammo_n = ammo;
    hit_n = 1'b0;
    miss_n = 1'b0;
    case (state)
      ST_IDLE:
        if (fire_rise && ammo != 2'd0) begin
          bul_x_n = {1'b0, pos_x} + 11'(BARREL_OFS);
          bul_y_n = 10'(SPAWN_Y);
          ammo_n = ammo - 2'd1;
          state_n = ST_FLYING;
        end
      ST_FLYING:
        if (tick) begin
          if (duck_alive && duck_ov) begin
            hit_n = 1'b1;
            cd_n = CW'(COOLDOWN);
            state_n = ST_COOLDOWN;
          end else if (bul_y == 10'd0) begin
            miss_n = 1'b1;
            cd_n = CW'(COOLDOWN);
            state_n = ST_COOLDOWN;
          end else begin
            bul_y_n = bul_y - 10'd1;
          end
        end
      ST_COOLDOWN:
        if (cd == '0) state_n = ST_IDLE;
        else if (tick) cd_n = cd - 1'b1;
      default: state_n = ST_IDLE;
    endcase
    // A new round refills the magazine even over a shot accepted this cycle.
    if (reload) ammo_n = 2'(AMMO_MAX);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ammo <= 2'(AMMO_MAX);
      bul_x <= '0;
      bul_y <= '0;
      cd <= '0;
      cnt <= '0;
      fire_q <= 1'b0;
      data <= COL_BLACK;
      draw <= 1'b0;
      hit <= 1'b0;
      miss <= 1'b0;
    end else begin
      state <= state_n;
      ammo <= ammo_n;
      bul_x <= bul_x_n;
      bul_y <= bul_y_n;
      cd <= cd_n;
      cnt <= tick ? 16'd0 : cnt + 16'd1;
      fire_q <= fire;
      draw <= state == ST_FLYING && pix_ov;
      data <= (state == ST_FLYING && pix_ov) ? COLOR : COL_BLACK;
      hit <= hit_n;
      miss <= miss_n;
    end
  end
endmodule

// File: tb/tb_bullet_ctrl.sv
// tb_bullet_ctrl: scoreboard bench for bullet_ctrl with a fast tick (TICK_DIV=4).
module tb_bullet_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic [9:0] hcount = '0, vcount = '0, pos_x = '0, duck_x = '0, duck_y = '0;
  logic fire = 1'b0, reload = 1'b0, duck_alive = 1'b0;
  logic [5:0] data;
  logic draw, hit, miss, busy;
  logic [1:0] ammo;
  int total = 0, bad = 0, cyc = 0, hit_cnt = 0, miss_cnt = 0;
  typedef struct {string tag; int val;} exp_t;
  exp_t sb[$];

  bullet_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .pos_x(pos_x),
    .fire(fire), .reload(reload), .duck_x(duck_x), .duck_y(duck_y),
    .duck_alive(duck_alive), .data(data), .draw(draw), .hit(hit), .miss(miss),
    .ammo(ammo), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    hit_cnt += int'(hit);
    miss_cnt += int'(miss);
  end

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== 32'(exp)) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int val);
    sb.push_back('{tag, val});
  endtask

  task automatic pop(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty got=%0d exp=none", got);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic pix(input int h, input int v, input bit on, input string tag);
    hcount = 10'(h);
    vcount = 10'(v);
    push(tag, on ? 124 : 0);
    @(negedge clk);
    pop({draw, data});
  endtask

  task automatic fire_edge(output int launch);
    @(negedge clk) fire = 1'b1;
    @(negedge clk) fire = 1'b0;
    launch = cyc;
  endtask

  task automatic pulse_reload();
    @(negedge clk) reload = 1'b1;
    @(negedge clk) reload = 1'b0;
  endtask

  // sel: 0 = hit, 1 = miss, 2 = idle; ev is the clock count at the event or -1
  task automatic wait_ev(input int sel, input int limit, output int ev);
    ev = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((sel == 0 && hit) || (sel == 1 && miss) || (sel == 2 && !busy)) begin
        ev = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t0, ev, e2, h0, m0;
    pos_x = 10'd100;
    repeat (3) @(negedge clk);
    check("rst_draw", draw, 0);
    check("rst_data", data, 0);
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    check("rst_ammo", ammo, 3);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // launch, pixel window, latched x, then a full flight to the top
    fire_edge(t0);
    check("launch_ammo", ammo, 2);
    check("launch_busy", busy, 1);
    pix(103, 427, 1, "pix_origin");
    pix(107, 427, 0, "pix_right_out");
    pix(102, 430, 0, "pix_left_out");
    pix(106, 430, 1, "pix_right_in");
    pix(103, 435, 0, "pix_below");
    pos_x = 10'd300;
    fire_edge(ev);
    check("refire_ammo", ammo, 2);
    pix(103, 430, 1, "pix_latched_x");
    pix(303, 430, 0, "pix_new_x");
    h0 = hit_cnt;
    push("miss_latency", 1);
    wait_ev(1, 2000, ev);
    pop(ev >= 0 && ev - t0 >= 1709 && ev - t0 <= 1712);
    @(negedge clk);
    check("miss_width", miss, 0);
    wait_ev(2, 60, e2);
    check("miss_cool_len", e2 - ev, 33);
    check("miss_no_hit", hit_cnt - h0, 0);

    // immediate hit at the spawn point
    pos_x = 10'd100;
    pulse_reload();
    check("reload_ammo", ammo, 3);
    duck_x = 10'd95;
    duck_y = 10'd400;
    duck_alive = 1'b1;
    m0 = miss_cnt;
    fire_edge(t0);
    check("hit_launch_ammo", ammo, 2);
    push("hit_latency", 1);
    wait_ev(0, 8, ev);
    pop(ev >= 0 && ev - t0 >= 1 && ev - t0 <= 4);
    pix(103, 430, 0, "pix_cooldown");
    check("hit_width", hit, 0);
    wait_ev(2, 60, e2);
    check("hit_cool_len", e2 - ev, 33);
    check("hit_no_miss", miss_cnt - m0, 0);

    // hit and miss on the same tick: hit wins
    pulse_reload();
    duck_y = 10'd0;
    duck_alive = 1'b0;
    h0 = hit_cnt;
    m0 = miss_cnt;
    fire_edge(t0);
    repeat (1708) @(negedge clk);
    duck_alive = 1'b1;
    push("tie_hit", 1);
    wait_ev(0, 8, ev);
    pop(ev >= 0 && ev - t0 >= 1709 && ev - t0 <= 1712);
    wait_ev(2, 60, e2);
    check("tie_no_miss", miss_cnt - m0, 0);
    check("tie_one_hit", hit_cnt - h0, 1);

    // ammo accounting with a held button
    pulse_reload();
    duck_y = 10'd400;
    @(negedge clk) fire = 1'b1;
    repeat (1000) @(negedge clk);
    check("hold_ammo", ammo, 2);
    check("hold_busy", busy, 0);
    fire = 1'b0;
    @(negedge clk);
    fire_edge(t0);
    check("shot2_ammo", ammo, 1);
    wait_ev(2, 60, ev);
    check("shot2_done", ev >= 0, 1);
    fire_edge(t0);
    check("shot3_ammo", ammo, 0);
    wait_ev(2, 60, ev);
    check("shot3_done", ev >= 0, 1);
    fire_edge(t0);
    check("empty_ammo", ammo, 0);
    check("empty_busy", busy, 0);
    pulse_reload();
    check("refill_ammo", ammo, 3);
    @(negedge clk) begin fire = 1'b1; reload = 1'b1; end
    @(negedge clk) begin fire = 1'b0; reload = 1'b0; end
    check("reload_wins_ammo", ammo, 3);
    check("reload_wins_busy", busy, 1);
    wait_ev(2, 60, ev);

    // asynchronous reset mid-flight
    duck_alive = 1'b0;
    fire_edge(t0);
    hcount = 10'd103;
    vcount = 10'd430;
    repeat (10) @(negedge clk);
    check("pre_rst_draw", draw, 1);
    check("pre_rst_ammo", ammo, 2);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_draw", draw, 0);
    check("arst_data", data, 0);
    check("arst_busy", busy, 0);
    check("arst_ammo", ammo, 3);
    check("arst_hit", hit, 0);
    check("arst_miss", miss, 0);
    h0 = hit_cnt;
    m0 = miss_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2000) @(negedge clk);
    check("post_rst_hits", hit_cnt - h0, 0);
    check("post_rst_misses", miss_cnt - m0, 0);
    check("post_rst_busy", busy, 0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
